inst_encode_loader: RTL

- Encoder side of the instruction field format. Accepts field-level instruction requests (opcode, rd, rs1, rs2, fun3, fun7, imm) over a valid/ready handshake.
- Packs each request into a 32-bit RV32I word and writes it sequentially into instruction memory from BASE_ADDR.
- Used as a boot/program loader ahead of fetch. Output words, fed back through the field decoder, must reproduce the input fields for every supported opcode.

---
 rtl/inst_encode_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/inst_encode_loader.sv
// Boot-time program loader: packs field-level RV32I requests into 32-bit words and
// writes them sequentially into instruction memory starting at BASE_ADDR.
module inst_encode_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        fun3,
    input  logic [6:0]        fun7,
    input  logic [31:0]       imm,
    input  logic              last,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              last_q, last_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       enc_word;
    logic              legal;

    always_comb begin
        legal    = 1'b1;
        enc_word = 32'h0;
        case (opcode)
            7'b0110011:
                enc_word = {fun7, rs2, rs1, fun3, rd, opcode};
            7'b0010011, 7'b0000011, 7'b1100111:
                enc_word = {imm[11:0], rs1, fun3, rd, opcode};
            7'b0100011:
                enc_word = {imm[11:5], rs2, rs1, fun3, imm[4:0], opcode};
            7'b1100011:
                enc_word = {imm[12], imm[10:5], rs2, rs1, fun3, imm[4:1], imm[11], opcode};
            7'b0110111, 7'b0010111:
                enc_word = {imm[31:12], rd, opcode};
            7'b1101111:
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default:
                legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        last_d  = last_q;
        word_d  = word_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (legal) begin
                        word_d  = enc_word;
                        last_d  = last;
                        addr_d  = BASE_ADDR + 32'({count_q, 2'b00});
                        state_d = StWrite;
                    end else begin
                        err_d = 1'b1;
                        if (last) state_d = StDone;
                    end
                end
            end
            StWrite: begin
                count_d = count_q + 1'b1;
                if (last_q) begin
                    state_d = StDone;
                end else if (count_q == LAST_IDX) begin
                    // Memory full before the program ended: overflow.
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (start) begin
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            word_q  <= 32'h0;
            addr_q  <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            last_q  <= last_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
        end
    end

    // Strobe decoded from state so an async reset drops it in the same cycle.
    assign mem_we    = (state_q == StWrite);
    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StWrite);
    assign done      = (state_q == StDone);
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule
